// File: rtl/axi_llc_pkg.sv
`default_nettype none
// ============================================================================
// axi_llc_pkg: sweep-mode and sweeper FSM types shared by the LLC sweeper.
// Revision: 1.0
// ============================================================================
package axi_llc_pkg;

  typedef enum logic {
    SWEEP_READ = 1'b0,
    SWEEP_FILL = 1'b1
  } sweep_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_e;

  // Address width for an n-word array; a single-word array still needs one bit.
  function automatic int unsigned addr_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_v3.sv
`default_nettype none
// ============================================================================
// fifo_v3: synchronous FIFO, any depth >= 1; push when full / pop when empty
// are ignored. Revision: 1.0
// ============================================================================
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);
  localparam int unsigned PtrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntWidth = $clog2(DEPTH + 1);
  localparam logic [PtrWidth-1:0] c_last_ptr = PtrWidth'(DEPTH - 1);
  localparam logic [PtrWidth-1:0] c_ptr_one  = PtrWidth'(1);
  localparam logic [CntWidth-1:0] c_depth    = CntWidth'(DEPTH);
  localparam logic [CntWidth-1:0] c_cnt_one  = CntWidth'(1);

  logic [DATA_WIDTH-1:0] r_mem [2**PtrWidth];
  logic [PtrWidth-1:0]   r_wr_ptr;
  logic [PtrWidth-1:0]   r_rd_ptr;
  logic [CntWidth-1:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  assign full_o  = (r_count == c_depth);
  assign empty_o = (r_count == '0);
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign data_o  = r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + c_ptr_one;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/axi_llc_sram_sweeper.sv
`default_nettype none
// ============================================================================
// axi_llc_sram_sweeper: sweeps a wrapping SRAM address range as streamed reads
// or constant-pattern fill writes. Revision: 1.0
// ============================================================================
module axi_llc_sram_sweeper
  import axi_llc_pkg::*;
#(
  parameter  int unsigned NumWords  = 1024,
  parameter  int unsigned DataWidth = 128,
  parameter  int unsigned ByteWidth = 8,
  parameter  int unsigned Latency   = 1,
  parameter  int unsigned BufDepth  = Latency + 2,
  localparam int unsigned AddrWidth = addr_bits(NumWords),
  localparam int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 mode_i,
  input  logic [AddrWidth-1:0] start_addr_i,
  input  logic [AddrWidth:0]   num_words_i,
  input  logic [DataWidth-1:0] fill_data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [DataWidth-1:0] rdata_o,
  output logic                 rdata_last_o,
  output logic                 rdata_valid_o,
  input  logic                 rdata_ready_i,
  output logic                 req_o,
  output logic                 we_o,
  output logic [AddrWidth-1:0] addr_o,
  output logic [DataWidth-1:0] wdata_o,
  output logic [BeWidth-1:0]   be_o,
  input  logic                 gnt_i,
  input  logic [DataWidth-1:0] rdata_i
);
  localparam int unsigned CreditWidth = $clog2(BufDepth + 1);
  localparam logic [AddrWidth-1:0]   c_last_addr  = AddrWidth'(NumWords - 1);
  localparam logic [AddrWidth-1:0]   c_addr_one   = AddrWidth'(1);
  localparam logic [AddrWidth:0]     c_rem_one    = (AddrWidth + 1)'(1);
  localparam logic [CreditWidth-1:0] c_buf_depth  = CreditWidth'(BufDepth);
  localparam logic [CreditWidth-1:0] c_credit_one = CreditWidth'(1);

  sweep_state_e           r_state;
  sweep_state_e           w_state_next;
  sweep_mode_e            r_mode;
  logic [AddrWidth-1:0]   r_addr;
  logic [AddrWidth:0]     r_remaining;
  logic [DataWidth-1:0]   r_fill;
  logic [CreditWidth-1:0] r_credit;
  logic [Latency-1:0]     r_pipe_valid;
  logic [Latency-1:0]     r_pipe_last;

  logic                   w_load;
  logic                   w_req;
  logic                   w_hs;
  logic                   w_rd_hs;
  logic                   w_hs_last;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic [DataWidth:0]     w_fifo_rdata;

  // Read requests stay raised once asserted: credit only falls while waiting for grant.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_req        = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_load       = 1'b1;
          w_state_next = (num_words_i == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        w_req = (r_mode == SWEEP_FILL) || (r_credit < c_buf_depth);
        if (w_req && gnt_i && (r_remaining == c_rem_one)) w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((r_mode == SWEEP_FILL) || (r_credit == '0)) w_state_next = ST_DONE;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign w_hs      = w_req & gnt_i;
  assign w_rd_hs   = w_hs & (r_mode == SWEEP_READ);
  assign w_hs_last = w_hs & (r_remaining == c_rem_one);
  assign w_push    = r_pipe_valid[Latency-1];
  assign w_pop     = rdata_valid_o & rdata_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mode       <= SWEEP_READ;
      r_addr       <= '0;
      r_remaining  <= '0;
      r_fill       <= '0;
      r_credit     <= '0;
      r_pipe_valid <= '0;
      r_pipe_last  <= '0;
    end else begin
      if (w_load) begin
        r_mode      <= sweep_mode_e'(mode_i);
        r_addr      <= start_addr_i;
        r_remaining <= num_words_i;
        r_fill      <= fill_data_i;
      end else if (w_hs) begin
        r_addr      <= (r_addr == c_last_addr) ? '0 : r_addr + c_addr_one;
        r_remaining <= r_remaining - c_rem_one;
      end
      r_pipe_valid <= (r_pipe_valid << 1) | Latency'(w_rd_hs);
      r_pipe_last  <= (r_pipe_last << 1) | Latency'(w_rd_hs & w_hs_last);
      case ({w_rd_hs, w_pop})
        2'b10:   r_credit <= r_credit + c_credit_one;
        2'b01:   r_credit <= r_credit - c_credit_one;
        default: r_credit <= r_credit;
      endcase
    end
  end

  fifo_v3 #(
    .DATA_WIDTH (DataWidth + 1),
    .DEPTH      (BufDepth)
  ) u_ret_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (1'b0),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .data_i  ({r_pipe_last[Latency-1], rdata_i}),
    .push_i  (w_push),
    .data_o  (w_fifo_rdata),
    .pop_i   (w_pop)
  );

  assign busy_o        = (r_state != ST_IDLE);
  assign done_o        = (r_state == ST_DONE);
  assign req_o         = w_req;
  assign we_o          = w_req & (r_mode == SWEEP_FILL);
  assign addr_o        = r_addr;
  assign wdata_o       = r_fill;
  assign be_o          = we_o ? {BeWidth{1'b1}} : '0;
  assign rdata_valid_o = ~w_fifo_empty;
  assign rdata_o       = w_fifo_rdata[DataWidth-1:0];
  assign rdata_last_o  = rdata_valid_o & w_fifo_rdata[DataWidth];

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) !(w_push && w_fifo_full));
  a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i) r_credit <= c_buf_depth);

endmodule
`default_nettype wire
